// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster timing generator.
// A clock divider produces a one-clk pixel strobe. Horizontal and vertical
// counters advance on that strobe. Blanking and sync are decoded
// combinationally from the registered counters, so they always match the
// counters shown in the same cycle. Per-frame and game-rate ticks let
// downstream logic run on clk through an enable.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,  // system clocks per pixel, >= 2
  parameter int MOVE_DIV = 2   // frames per move_tick, >= 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        hSync,
  output logic        vSync,
  output logic        frame_tick,
  output logic        move_tick,
  output logic [15:0] frame_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MOV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [MOV_W-1:0] MOV_LAST = MOV_W'(MOVE_DIV - 1);

  // Horizontal geometry in pixels
  localparam logic [9:0] H_LAST      = 10'd799;
  localparam logic [9:0] H_SYNC_END  = 10'd95;
  localparam logic [9:0] H_VIS_START = 10'd144;
  localparam logic [9:0] H_VIS_END   = 10'd783;

  // Vertical geometry in lines
  localparam logic [9:0] V_LAST      = 10'd524;
  localparam logic [9:0] V_SYNC_END  = 10'd1;
  localparam logic [9:0] V_VIS_START = 10'd35;
  localparam logic [9:0] V_VIS_END   = 10'd514;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic [MOV_W-1:0] move_div;
  logic [MOV_W-1:0] move_div_nxt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic [15:0]      frame_cnt_nxt;
  logic             line_end;
  logic             frame_end;
  logic             frame_wrap;

  // Next-state for divider, raster counters and frame bookkeeping
  always_comb begin
    div_nxt       = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    line_end      = (hCount == H_LAST);
    frame_end     = line_end && (vCount == V_LAST);
    frame_wrap    = pix_en && frame_end;
    h_nxt         = hCount;
    v_nxt         = vCount;
    frame_cnt_nxt = frame_cnt;
    move_div_nxt  = move_div;
    if (pix_en) begin
      h_nxt = line_end ? 10'd0 : hCount + 10'd1;
      if (line_end) begin
        v_nxt = (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
      end
    end
    if (frame_wrap) begin
      frame_cnt_nxt = frame_cnt + 16'd1;
      move_div_nxt  = (move_div == MOV_LAST) ? '0 : move_div + MOV_W'(1);
    end
  end

  // Registered state; pix_en is set together with div reaching its last value
  // so the strobe occupies exactly the cycle where div == CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      pix_en     <= 1'b0;
      hCount     <= 10'd0;
      vCount     <= 10'd0;
      frame_cnt  <= 16'd0;
      move_div   <= '0;
      frame_tick <= 1'b0;
      move_tick  <= 1'b0;
    end else begin
      div        <= div_nxt;
      pix_en     <= (div_nxt == DIV_LAST);
      hCount     <= h_nxt;
      vCount     <= v_nxt;
      frame_cnt  <= frame_cnt_nxt;
      move_div   <= move_div_nxt;
      frame_tick <= frame_wrap;
      move_tick  <= frame_wrap && (move_div == MOV_LAST);
    end
  end

  // Visible window and active-low syncs decoded from the current counters
  always_comb begin
    bright = (hCount >= H_VIS_START) && (hCount <= H_VIS_END) &&
             (vCount >= V_VIS_START) && (vCount <= V_VIS_END);
    hSync  = !(hCount <= H_SYNC_END);
    vSync  = !(vCount <= V_SYNC_END);
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// A reference model keeps a linear pixel index and pushes the expected
// outputs every clock; a checker pops them at the falling edge. Long spans
// (mid-frame, end of frame) are reached by forcing the raster counters for
// one non-pixel clock and re-seeding the model to the same point.
module tb_vga_timing_gen;

  localparam int CD = 4;
  localparam int MD = 2;
  localparam int PIX_PER_FRAME = 800 * 525;

  logic        clk;
  logic        rst;
  logic        pix_en;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic        hSync;
  logic        vSync;
  logic        frame_tick;
  logic        move_tick;
  logic [15:0] frame_cnt;

  vga_timing_gen #(.CLK_DIV(CD), .MOVE_DIV(MD)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hCount     (hCount),
    .vCount     (vCount),
    .bright     (bright),
    .hSync      (hSync),
    .vSync      (vSync),
    .frame_tick (frame_tick),
    .move_tick  (move_tick),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pe;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        br;
    logic        hs;
    logic        vs;
    logic        ft;
    logic        mt;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  logic        chk_en  = 1'b0;
  logic        pre_req = 1'b0;
  logic [9:0]  pre_h   = 10'd0;
  logic [9:0]  pre_v   = 10'd0;
  logic [15:0] pre_f   = 16'd0;
  logic        hs_en   = 1'b0;
  int          hs_low  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: linear pixel index, phase within the pixel, frames
  int m_ph = 0;
  int m_p  = 0;
  int m_f  = 0;
  int m_w  = 0;
  bit m_ft = 0;
  bit m_mt = 0;

  always @(posedge clk) begin
    exp_t e;
    int   h;
    int   v;
    if (rst) begin
      m_ph = 0; m_p = 0; m_f = 0; m_w = 0; m_ft = 0; m_mt = 0;
    end else begin
      m_ft = 0;
      m_mt = 0;
      if (m_ph == CD - 1) begin
        if (m_p == PIX_PER_FRAME - 1) begin
          m_p  = 0;
          m_f  = (m_f + 1) % 65536;
          m_w  = m_w + 1;
          m_ft = 1;
          m_mt = ((m_w % MD) == 0);
        end else begin
          m_p = m_p + 1;
        end
      end
      m_ph = (m_ph + 1) % CD;
      if (pre_req) begin
        m_p = int'(pre_v) * 800 + int'(pre_h);
        m_f = int'(pre_f);
      end
    end
    h    = m_p % 800;
    v    = m_p / 800;
    e.pe = (m_ph == CD - 1);
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.br = (h >= 144) && (h <= 783) && (v >= 35) && (v <= 514);
    e.hs = (h > 95);
    e.vs = (v > 1);
    e.ft = m_ft;
    e.mt = m_mt;
    e.fc = 16'(m_f);
    sb.push_back(e);
  end

  // Checker: pops one expected entry per clock, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (chk_en) begin
        check_val("pix_en",     32'(pix_en),     32'(e.pe));
        check_val("hCount",     32'(hCount),     32'(e.h));
        check_val("vCount",     32'(vCount),     32'(e.v));
        check_val("bright",     32'(bright),     32'(e.br));
        check_val("hSync",      32'(hSync),      32'(e.hs));
        check_val("vSync",      32'(vSync),      32'(e.vs));
        check_val("frame_tick", 32'(frame_tick), 32'(e.ft));
        check_val("move_tick",  32'(move_tick),  32'(e.mt));
        check_val("frame_cnt",  32'(frame_cnt),  32'(e.fc));
      end
    end
    if (hs_en && pix_en && (vCount == 10'd0) && !hSync) hs_low++;
  end

  // Decoder probe: pin the counters and read the decoded outputs
  task probe(input logic [9:0] ph, input logic [9:0] pv,
             input logic eb, input logic ehs, input logic evs, input string tag);
    pre_h = ph;
    pre_v = pv;
    force dut.hCount = pre_h;
    force dut.vCount = pre_v;
    #1;
    check_val({tag, "_bright"}, 32'(bright), 32'(eb));
    check_val({tag, "_hSync"},  32'(hSync),  32'(ehs));
    check_val({tag, "_vSync"},  32'(vSync),  32'(evs));
    release dut.hCount;
    release dut.vCount;
    #1;
  endtask

  // Jump the raster to (ph,pv) with frame count pf during a non-pixel clock
  task preload(input logic [9:0] ph, input logic [9:0] pv, input logic [15:0] pf);
    int n;
    n = 0;
    @(negedge clk);
    while (!pix_en && n < 2 * CD) begin
      @(negedge clk);
      n++;
    end
    check_val("wait_pix_en", 32'(pix_en), 32'd1);
    @(negedge clk);
    #1;
    pre_h = ph;
    pre_v = pv;
    pre_f = pf;
    force dut.hCount    = pre_h;
    force dut.vCount    = pre_v;
    force dut.frame_cnt = pre_f;
    pre_req = 1'b1;
    @(negedge clk);
    #1;
    release dut.hCount;
    release dut.vCount;
    release dut.frame_cnt;
    pre_req = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    probe(10'd143, 10'd35,  1'b0, 1'b1, 1'b1, "p143_35");
    probe(10'd144, 10'd35,  1'b1, 1'b1, 1'b1, "p144_35");
    probe(10'd783, 10'd514, 1'b1, 1'b1, 1'b1, "p783_514");
    probe(10'd784, 10'd514, 1'b0, 1'b1, 1'b1, "p784_514");
    probe(10'd144, 10'd34,  1'b0, 1'b1, 1'b1, "p144_34");
    probe(10'd144, 10'd515, 1'b0, 1'b1, 1'b1, "p144_515");
    probe(10'd95,  10'd1,   1'b0, 1'b0, 1'b0, "p95_1");
    probe(10'd96,  10'd2,   1'b0, 1'b1, 1'b1, "p96_2");

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check_val("rst_pix_en", 32'(pix_en),     32'd0);
    check_val("rst_hCount", 32'(hCount),     32'd0);
    check_val("rst_vCount", 32'(vCount),     32'd0);
    check_val("rst_hSync",  32'(hSync),      32'd0);
    check_val("rst_vSync",  32'(vSync),      32'd0);
    check_val("rst_bright", 32'(bright),     32'd0);
    check_val("rst_ftick",  32'(frame_tick), 32'd0);
    check_val("rst_mtick",  32'(move_tick),  32'd0);
    check_val("rst_fcnt",   32'(frame_cnt),  32'd0);

    #1;
    rst   = 1'b0;
    hs_en = 1'b1;
    repeat (3) @(negedge clk);
    check_val("first_pix_en", 32'(pix_en), 32'd1);
    check_val("first_h0",     32'(hCount), 32'd0);
    @(negedge clk);
    check_val("clk4_pix_en",  32'(pix_en), 32'd0);
    check_val("clk4_h1",      32'(hCount), 32'd1);

    n = 0;
    while (hCount != 10'd799 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_val("reach_h799", 32'(hCount), 32'd799);
    n = 0;
    while (hCount == 10'd799 && n < 2 * CD) begin
      @(negedge clk);
      n++;
    end
    check_val("line_wrap_h", 32'(hCount), 32'd0);
    check_val("line_wrap_v", 32'(vCount), 32'd1);
    hs_en = 1'b0;
    check_val("hsync_low_pixels", 32'(hs_low), 32'd96);

    preload(10'd500, 10'd300, 16'd7);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_h",     32'(hCount),     32'd0);
    check_val("midrst_v",     32'(vCount),     32'd0);
    check_val("midrst_fcnt",  32'(frame_cnt),  32'd0);
    check_val("midrst_ftick", 32'(frame_tick), 32'd0);
    #1;
    rst = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      preload(10'd799, 10'd524, (k == 1) ? 16'hFFFF : 16'(k - 2));
      n = 0;
      while (!frame_tick && n < 4 * CD) begin
        @(negedge clk);
        n++;
      end
      check_val("wrap_ftick", 32'(frame_tick), 32'd1);
      check_val("wrap_h",     32'(hCount),     32'd0);
      check_val("wrap_v",     32'(vCount),     32'd0);
      check_val("wrap_fcnt",  32'(frame_cnt),  (k == 1) ? 32'd0 : 32'(k - 1));
      check_val("wrap_mtick", 32'(move_tick),  ((k % 2) == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
      check_val("ftick_one_clk", 32'(frame_tick), 32'd0);
      check_val("mtick_one_clk", 32'(move_tick),  32'd0);
    end

    repeat (3 * 800 * CD + 50) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing for the game display path. Sits directly upstream of `block_controller`: drives its `hCount`, `vCount` and `bright` inputs, and drives the monitor's `hSync`/`vSync` pins. Also produces per-frame and game-rate tick pulses, so movement logic can run from the system clock through an enable instead of a derived slow clock.

## Interface

Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz → 25 MHz); must be ≥2.
- `MOVE_DIV`, 2: frames per `move_tick`; must be ≥1.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset. Synchronous, active-high.
- `pix_en` out 1: one-`clk` pixel strobe, once every `CLK_DIV` clocks.
- `hCount` out 10: horizontal position, 0..799.
- `vCount` out 10: vertical position, 0..524.
- `bright` out 1: high inside the visible window.
- `hSync` out 1: horizontal sync, active low.
- `vSync` out 1: vertical sync, active low.
- `frame_tick` out 1: one-`clk` pulse at the start of each frame.
- `move_tick` out 1: one-`clk` pulse every `MOVE_DIV` frames.
- `frame_cnt` out 16: count of completed frames, wraps modulo 2^16.

## Operation

- Divider `div` counts 0..`CLK_DIV`-1 and wraps. `pix_en` is a registered output, high for exactly the `clk` cycle in which `div` equals `CLK_DIV`-1.
- On each `clk` edge with `pix_en` high:
  - `hCount` increments. 799 wraps to 0.
  - When `hCount` wraps, `vCount` increments. 524 wraps to 0.
  - `hCount` and `vCount` hold on all other edges.
- Horizontal constants: total 800, sync 0..95, back porch 96..143, visible 144..783, front porch 784..799.
- Vertical constants: total 525, sync 0..1, back porch 2..34, visible 35..514, front porch 515..524.
- Decoded outputs are combinational from the registered counters, so they are always consistent with the `hCount`/`vCount` of the same cycle:
  - `bright` = (144 ≤ `hCount` ≤ 783) && (35 ≤ `vCount` ≤ 514).
  - `hSync` = !(`hCount` ≤ 95).
  - `vSync` = !(`vCount` ≤ 1).
- Frame wrap is the `pix_en` edge that moves the counters from (799,524) to (0,0). On that edge:
  - `frame_tick` is registered high for one `clk`.
  - `frame_cnt` increments.
  - Internal `move_div` counter (0..`MOVE_DIV`-1) advances. `move_tick` is registered high for one `clk` on the frame wrap where `move_div` returns to 0.
- Reset values. Applied on the first rising `clk` with `rst` high, regardless of state:
  - `div`=0, `hCount`=0, `vCount`=0, `frame_cnt`=0, `move_div`=0.
  - `pix_en`=0, `frame_tick`=0, `move_tick`=0.
  - Hence `bright`=0, `hSync`=0, `vSync`=0.
  - Reset does not generate `frame_tick` or `move_tick`.
- Reset asserted mid-frame or mid-pixel aborts the frame. The counters restart from (0,0) with no partial tick. Holding `rst` high keeps all state at its reset value.
- `pix_en`, `frame_tick` and `move_tick` are never held longer than one `clk`. `frame_tick` and `move_tick` coincide with the `pix_en`-aligned cycle following the wrap edge.

## Timing

- First `pix_en` is at the `CLK_DIV`th rising edge after `rst` deasserts. The first `hCount` change (0→1) appears on that same edge.
- Line period: 800·`CLK_DIV` clk (3200 at default). Frame period: 525 lines (1,680,000 clk at default).
- Counter and tick outputs have 1-cycle register latency from the enabling condition. Decoded outputs (`bright`, syncs) have 0 added latency relative to the counters.
- `block_controller` samples `hCount`/`vCount`/`bright` combinationally; its `rgb` must be registered on `pix_en` by the display stage.

## Test plan

- Reset then release:
  - Required while reset is applied: all outputs at their reset values, with `hSync`=0 and `vSync`=0.
  - Required after release: `pix_en` pulses at clk 4, 8, 12…, and `hCount` reaches 1 at clk 4.
- Line wrap: run to `hCount`=799 → the next `pix_en` gives `hCount`=0 and `vCount`+1. `hSync` is low for exactly 96 pixels per line.
- Visible window:
  - Probe (143,35), (144,35), (783,514), (784,514), (144,34), (144,515).
  - Required `bright`: 0, 1, 1, 0, 0, 0.
- Frame wrap:
  - At (799,524) + `pix_en` → counters (0,0), `frame_tick` high for 1 clk, `frame_cnt` 0→1.
  - `move_tick` is high on frames 2, 4, 6 (with `MOVE_DIV`=2).
  - `vSync` is low only for `vCount` 0..1.
- Reset mid-frame at (500,300) for 1 clk → next cycle counters (0,0), `frame_cnt`=0, no `frame_tick`. The next `frame_tick` follows exactly 1,680,000 clk later.
- `frame_cnt` rollover: preload to 65535 via forced frame wraps → next wrap gives 0 with `frame_tick` still asserted.
